// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register map, LSR bit positions and FSM encodings for uart_mmio
package uart_mmio_pkg;
  localparam logic [63:0] UART_BASE = 64'h0000_0000_1000_0000;

  localparam logic [2:0] UART_THR = 3'd0;
  localparam logic [2:0] UART_RBR = 3'd0;
  localparam logic [2:0] UART_LSR = 3'd5;
  localparam logic [2:0] UART_SCR = 3'd7;

  localparam int LSR_DR   = 0;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  localparam logic [7:0] RX_NO_DATA = 8'hFF;

  typedef enum logic [1:0] {RIDLE, RRESP, RWAIT} rd_state_e;
  typedef enum logic [1:0] {WIDLE, WFULL, WRESP, WWAIT} wr_state_e;

  function automatic logic [7:0] lane_byte(input logic [63:0] v, input logic [2:0] off);
    return v[{off, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO for the transmit path
// Pointers carry one extra bit so full and empty differ only in the MSB.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic        do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop   = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped UART: THR/RBR/LSR/SCR window with one-cycle rok/wok pulses
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = UART_BASE,
  parameter int          TX_DEPTH  = 8,
  parameter int          TX_GAP    = 0,
  parameter int          RX_POLL   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ren,
  input  logic [63:0] raddr,
  output logic [63:0] rdata,
  output logic        rok,
  input  logic        wen,
  input  logic [63:0] waddr,
  input  logic [63:0] wdata,
  input  logic [63:0] wmask,
  output logic        wok,
  output logic        hit_r,
  output logic        hit_w,
  output logic        uart_out_valid,
  output logic [7:0]  uart_out_ch,
  output logic        uart_in_valid,
  input  logic [7:0]  uart_in_ch
);
  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
  localparam int PW = (RX_POLL > 1) ? $clog2(RX_POLL) : 1;

  rd_state_e   rd_state_q, rd_state_d;
  wr_state_e   wr_state_q, wr_state_d;
  logic [63:0] rdata_q, rdata_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [7:0]  scr_q, scr_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rx_valid_q, rx_valid_d;
  logic [PW-1:0] poll_q, poll_d;
  logic        in_valid_q, in_valid_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_ch_q, out_ch_d;

  logic        tx_push, tx_pop, tx_full, tx_empty, tx_busy;
  logic [7:0]  tx_push_data, tx_head;
  logic [CW-1:0] tx_count;
  logic        rx_pop;
  logic [7:0]  lsr, rd_byte, wr_lane;
  logic [2:0]  wr_off;
  logic        wr_lane_en;

  assign hit_r = (raddr[63:3] == BASE_ADDR[63:3]);
  assign hit_w = (waddr[63:3] == BASE_ADDR[63:3]);

  assign tx_busy = (gap_q != '0);
  assign tx_pop  = !tx_empty && !tx_busy;

  always_comb begin
    lsr           = 8'h00;
    lsr[LSR_DR]   = rx_valid_q;
    lsr[LSR_THRE] = !tx_full;
    lsr[LSR_TEMT] = (tx_count == '0) && !tx_busy;
  end

  uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = '0;
    rx_pop     = 1'b0;
    case (raddr[2:0])
      UART_RBR: rd_byte = rx_valid_q ? rx_buf_q : 8'h00;
      UART_LSR: rd_byte = lsr;
      UART_SCR: rd_byte = scr_q;
      default:  rd_byte = 8'h00;
    endcase
    case (rd_state_q)
      RIDLE: if (ren && hit_r) begin
        rdata_d    = {56'h0, rd_byte} << {raddr[2:0], 3'b000};
        rx_pop     = (raddr[2:0] == UART_RBR) && rx_valid_q;
        rd_state_d = RRESP;
      end
      RRESP:   rd_state_d = RWAIT;
      RWAIT:   if (!ren) rd_state_d = RIDLE;
      default: rd_state_d = RIDLE;
    endcase
  end

  always_comb begin
    wr_off       = waddr[2:0];
    wr_lane      = lane_byte(wdata, wr_off);
    wr_lane_en   = (lane_byte(wmask, wr_off) != 8'h00);
    wr_state_d   = wr_state_q;
    wbyte_d      = wbyte_q;
    scr_d        = scr_q;
    tx_push      = 1'b0;
    tx_push_data = (wr_state_q == WFULL) ? wbyte_q : wr_lane;
    case (wr_state_q)
      WIDLE: if (wen && hit_w) begin
        wr_state_d = WRESP;
        if (wr_lane_en && wr_off == UART_THR) begin
          wbyte_d = wr_lane;
          if (tx_full) wr_state_d = WFULL;
          else         tx_push    = 1'b1;
        end else if (wr_lane_en && wr_off == UART_SCR) begin
          scr_d = wr_lane;
        end
      end
      WFULL: begin
        tx_push = !tx_full || tx_pop;
        if (tx_push) wr_state_d = WRESP;
      end
      WRESP:   wr_state_d = WWAIT;
      WWAIT:   if (!wen) wr_state_d = WIDLE;
      default: wr_state_d = WIDLE;
    endcase
  end

  always_comb begin
    gap_d       = gap_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    if (tx_pop) begin
      out_valid_d = 1'b1;
      out_ch_d    = tx_head;
      gap_d       = GW'(TX_GAP);
    end else if (tx_busy) begin
      gap_d = gap_q - GW'(1);
    end
  end

  // The pop is applied before the poll sample so a same-cycle capture survives.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_buf_d   = rx_buf_q;
    poll_d     = poll_q;
    in_valid_d = 1'b0;
    if (rx_pop) rx_valid_d = 1'b0;
    if (in_valid_q && uart_in_ch != RX_NO_DATA) begin
      rx_valid_d = 1'b1;
      rx_buf_d   = uart_in_ch;
    end
    if (rx_valid_q) begin
      poll_d = '0;
    end else if (poll_q == PW'(RX_POLL - 1)) begin
      poll_d     = '0;
      in_valid_d = 1'b1;
    end else begin
      poll_d = poll_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_q  <= RIDLE;
      wr_state_q  <= WIDLE;
      rdata_q     <= '0;
      wbyte_q     <= '0;
      scr_q       <= '0;
      rx_buf_q    <= '0;
      rx_valid_q  <= 1'b0;
      poll_q      <= '0;
      in_valid_q  <= 1'b0;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      rd_state_q  <= rd_state_d;
      wr_state_q  <= wr_state_d;
      rdata_q     <= rdata_d;
      wbyte_q     <= wbyte_d;
      scr_q       <= scr_d;
      rx_buf_q    <= rx_buf_d;
      rx_valid_q  <= rx_valid_d;
      poll_q      <= poll_d;
      in_valid_q  <= in_valid_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign rok            = (rd_state_q == RRESP);
  assign rdata          = rdata_q;
  assign wok            = (wr_state_q == WRESP);
  assign uart_out_valid = out_valid_q;
  assign uart_out_ch    = out_ch_q;
  assign uart_in_valid  = in_valid_q;
endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - randomized directed bench for uart_mmio with a behavioural register/FIFO model
`timescale 1ns/1ps
module tb_uart_mmio;
  localparam logic [63:0] BASE  = 64'h0000_0000_1000_0000;
  localparam int          TXG   = 31;
  localparam int          POLL  = 16;
  localparam int          DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ren = 1'b0, wen = 1'b0;
  logic [63:0] raddr = '0, waddr = '0, wdata = '0, wmask = '0;
  logic [7:0]  uart_in_ch = 8'hFF;
  logic [63:0] rdata;
  logic        rok, wok, hit_r, hit_w, uart_out_valid, uart_in_valid;
  logic [7:0]  uart_out_ch;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] out_q[$];
  int         out_t[$];
  int         poll_t[$];
  logic [7:0] exp_tx[$];
  logic [7:0] m_scr;
  logic       m_rx_valid;
  logic [7:0] m_rx;

  uart_mmio #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH), .TX_GAP(TXG), .RX_POLL(POLL)) dut (
    .clock(clock), .reset(reset),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rok(rok),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask), .wok(wok),
    .hit_r(hit_r), .hit_w(hit_w),
    .uart_out_valid(uart_out_valid), .uart_out_ch(uart_out_ch),
    .uart_in_valid(uart_in_valid), .uart_in_ch(uart_in_ch)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (uart_out_valid === 1'b1) begin
      out_q.push_back(uart_out_ch);
      out_t.push_back(cyc);
    end
    if (uart_in_valid === 1'b1) poll_t.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lsr_of(input int occ, input bit busy, input bit rxv);
    return {1'b0, (occ == 0 && !busy), (occ < DEPTH), 4'b0000, rxv};
  endfunction

  function automatic logic [63:0] exp_rd(input logic [2:0] off, input logic [7:0] lsr);
    logic [7:0] b;
    case (off)
      3'd0:    b = m_rx_valid ? m_rx : 8'h00;
      3'd5:    b = lsr;
      3'd7:    b = m_scr;
      default: b = 8'h00;
    endcase
    return 64'(b) << (8 * off);
  endfunction

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [63:0] m,
                          input int budget, output int lat, output int wc);
    lat = -1;
    wc  = -1;
    wen = 1'b1; waddr = a; wdata = d; wmask = m;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (wok === 1'b1) begin
        lat = i;
        wc  = cyc;
        break;
      end
    end
    wen = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_read(input logic [63:0] a, input int hold,
                         output logic [63:0] d, output int nrok, output int lat);
    d = '0; nrok = 0; lat = -1;
    ren = 1'b1; raddr = a;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (rok === 1'b1) begin
        nrok++;
        d = rdata;
        if (lat < 0) lat = i;
      end
    end
    ren = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset(output int rel);
    reset = 1'b1; ren = 1'b0; wen = 1'b0; uart_in_ch = 8'hFF;
    tick();
    tick();
    reset = 1'b0;
    rel = cyc;
    m_scr = 8'h00; m_rx_valid = 1'b0; m_rx = 8'h00;
    out_q.delete(); out_t.delete(); poll_t.delete(); exp_tx.delete();
  endtask

  task automatic fill_thr(input int n, output int nslow);
    logic [63:0] d, m;
    logic [7:0]  b;
    int lat, wc;
    nslow = 0;
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      d = {$urandom(), $urandom()}; d[7:0] = b;
      m = {$urandom(), $urandom()}; m[7:0] = 8'h01 << $urandom_range(0, 7);
      exp_tx.push_back(b);
      do_write(BASE, d, m, 3, lat, wc);
      if (lat != 1) nslow++;
    end
  endtask

  initial begin
    logic [63:0] d, m;
    logic [7:0]  b;
    logic [2:0]  off;
    int lat, wc, nr, rl, rel, n0, bad, nslow;
    bit en, wok_seen;

    do_reset(rel);
    chk("rst_rok", 64'(rok), 64'd0);
    chk("rst_wok", 64'(wok), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_out_valid", 64'(uart_out_valid), 64'd0);
    chk("rst_out_ch", 64'(uart_out_ch), 64'd0);
    chk("rst_in_valid", 64'(uart_in_valid), 64'd0);

    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rok !== 1'b0 || wok !== 1'b0 || rdata !== 64'd0 || uart_out_valid !== 1'b0 || uart_out_ch !== 8'd0) bad++;
    end
    chk("idle_quiet", 64'(bad), 64'd0);
    chk("poll_count", 64'(poll_t.size()), 64'd2);
    chk("poll_first", 64'((poll_t.size() >= 1) ? poll_t[0] - rel : -1), 64'(POLL));
    chk("poll_period", 64'((poll_t.size() >= 2) ? poll_t[1] - poll_t[0] : -1), 64'(POLL));

    raddr = BASE + 64'd5; waddr = BASE - 64'd1; #1;
    chk("hit_r_in", 64'(hit_r), 64'd1);
    chk("hit_w_below", 64'(hit_w), 64'd0);
    raddr = BASE + 64'd8; waddr = BASE + 64'd7; #1;
    chk("hit_r_above", 64'(hit_r), 64'd0);
    chk("hit_w_in", 64'(hit_w), 64'd1);

    do_read(BASE + 64'd5, 3, d, nr, rl);
    chk("lsr_reset", d, exp_rd(3'd5, lsr_of(0, 0, 0)));
    chk("lsr_rok_count", 64'(nr), 64'd1);
    chk("rd_latency", 64'(rl), 64'd1);

    // single transmit byte
    d = {$urandom(), $urandom()}; d[7:0] = 8'h41;
    exp_tx.push_back(8'h41);
    do_write(BASE, d, 64'h0000_0000_0000_00FF, 5, lat, wc);
    chk("thr_wok_lat", 64'(lat), 64'd1);
    for (int i = 0; i < 10 && out_q.size() < 1; i++) tick();
    chk("tx1_count", 64'(out_q.size()), 64'd1);
    chk("tx1_byte", 64'((out_q.size() >= 1) ? out_q[0] : 8'hXX), 64'(exp_tx[0]));
    chk("tx1_delay", 64'((out_t.size() >= 1) ? out_t[0] - wc : -1), 64'd1);
    repeat (TXG + 3) tick();
    chk("tx1_once", 64'(out_q.size()), 64'd1);

    // receive path
    for (int i = 0; i < 2 * POLL && uart_in_valid !== 1'b1; i++) tick();
    chk("poll_seen", 64'(uart_in_valid), 64'd1);
    b = 8'($urandom_range(0, 254));
    uart_in_ch = b;
    tick();
    uart_in_ch = 8'hFF;
    m_rx = b; m_rx_valid = 1'b1;
    n0 = poll_t.size();
    do_read(BASE + 64'd5, 3, d, nr, rl);
    chk("lsr_rx_valid", d, exp_rd(3'd5, lsr_of(0, 0, 1)));
    do_read(BASE, 3, d, nr, rl);
    chk("rbr_data", d, exp_rd(3'd0, 8'h00));
    m_rx_valid = 1'b0;
    chk("no_poll_while_full", 64'(poll_t.size() - n0), 64'd0);
    do_read(BASE + 64'd5, 3, d, nr, rl);
    chk("lsr_rx_cleared", d, exp_rd(3'd5, lsr_of(0, 0, 0)));
    do_read(BASE, 3, d, nr, rl);
    chk("rbr_empty", d, 64'd0);

    // scratch register in the top lane
    d = {$urandom(), $urandom()}; d[63:56] = 8'hC3;
    do_write(BASE + 64'd7, d, 64'hFF00_0000_0000_0000, 5, lat, wc);
    m_scr = 8'hC3;
    chk("scr_wok", 64'(lat), 64'd1);
    do_read(BASE + 64'd7, 3, d, nr, rl);
    chk("scr_read", d, 64'hC300_0000_0000_0000);

    for (int it = 0; it < 8; it++) begin
      off = 3'($urandom_range(1, 7));
      en  = 1'($urandom_range(0, 1));
      d = {$urandom(), $urandom()};
      m = {$urandom(), $urandom()};
      m[8 * off +: 8] = en ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      do_write(BASE + 64'(off), d, m, 5, lat, wc);
      if (en && off == 3'd7) m_scr = d[8 * off +: 8];
      chk("rand_wok", 64'(lat), 64'd1);
      off = 3'($urandom_range(1, 7));
      do_read(BASE + 64'(off), 3, d, nr, rl);
      chk("rand_read", d, exp_rd(off, lsr_of(0, 0, 0)));
    end

    do_write(BASE, 64'h0000_0000_0000_0055, 64'hFFFF_FFFF_FFFF_FF00, 5, lat, wc);
    chk("thr_masked_wok", 64'(lat), 64'd1);
    repeat (6) tick();
    chk("thr_masked_no_tx", 64'(out_q.size()), 64'd1);

    do_read(BASE + 64'd7, 5, d, nr, rl);
    chk("hold_ren_one_rok", 64'(nr), 64'd1);
    do_read(BASE + 64'd8, 5, d, nr, rl);
    chk("miss_read_no_rok", 64'(nr), 64'd0);
    do_write(BASE + 64'd16, 64'hFF, 64'hFF, 5, lat, wc);
    chk("miss_write_no_wok", 64'(lat), -64'sd1);

    // fill the FIFO behind a slow transmitter
    out_q.delete(); out_t.delete(); exp_tx.delete();
    fill_thr(9, nslow);
    chk("fill_no_stall", 64'(nslow), 64'd0);
    do_read(BASE + 64'd5, 2, d, nr, rl);
    chk("lsr_full", d, exp_rd(3'd5, lsr_of(DEPTH, 1, 0)));
    b = 8'($urandom);
    exp_tx.push_back(b);
    do_write(BASE, 64'(b), 64'h1, 60, lat, wc);
    chk("wfull_stalled", 64'(lat > 1), 64'd1);
    chk("wfull_release_at_pop", 64'(wc), 64'((out_t.size() >= 2) ? out_t[1] : -2));
    for (int i = 0; i < 12 * (TXG + 1) && out_q.size() < 10; i++) tick();
    chk("drain_count", 64'(out_q.size()), 64'd10);
    do_read(BASE + 64'd5, 2, d, nr, rl);
    chk("lsr_gap_busy", d, exp_rd(3'd5, lsr_of(0, 1, 0)));
    for (int k = 0; k < 10; k++)
      chk("drain_order", 64'((k < out_q.size()) ? out_q[k] : 8'hXX), 64'(exp_tx[k]));
    bad = 0;
    for (int k = 1; k < out_t.size(); k++) if (out_t[k] - out_t[k-1] != TXG + 1) bad++;
    chk("drain_spacing", 64'(bad), 64'd0);
    repeat (TXG + 2) tick();
    do_read(BASE + 64'd5, 3, d, nr, rl);
    chk("lsr_drained", d, exp_rd(3'd5, lsr_of(0, 0, 0)));

    // reset while a store waits for space
    fill_thr(9, nslow);
    wen = 1'b1; waddr = BASE; wdata = 64'h77; wmask = 64'hFF;
    tick();
    tick();
    chk("wfull_wok_low", 64'(wok), 64'd0);
    reset = 1'b1; wen = 1'b0;
    tick();
    chk("rst_mid_wok", 64'(wok), 64'd0);
    chk("rst_mid_out_valid", 64'(uart_out_valid), 64'd0);
    tick();
    reset = 1'b0;
    m_scr = 8'h00;
    out_q.delete(); out_t.delete();
    wok_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (wok === 1'b1) wok_seen = 1;
    end
    chk("rst_mid_no_wok", 64'(wok_seen), 64'd0);
    chk("rst_mid_fifo_empty", 64'(out_q.size()), 64'd0);
    do_read(BASE + 64'd5, 3, d, nr, rl);
    chk("rst_mid_lsr", d, exp_rd(3'd5, lsr_of(0, 0, 0)));
    do_read(BASE + 64'd7, 3, d, nr, rl);
    chk("rst_mid_scr", d, exp_rd(3'd7, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
